// File: rtl/spi_master_buffer.sv
// SPI mode-0 initiator: shifts out 1-4 latched bytes MSB first and captures the
// same number of bytes from MISO into rx_data, generating SCLK and CS_N.
module spi_master_buffer #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  length,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_tx,
  input  logic        spi_rx
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_FINISH} state_t;

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);
  localparam logic [7:0] FIN_CNT  = 8'(CLK_DIV);

  state_t      r_state;
  state_t      w_nxt;
  logic [7:0]  r_cnt;
  logic [31:0] r_tx;
  logic [2:0]  r_len;
  logic [1:0]  r_byte;
  logic [2:0]  r_bit;
  logic [7:0]  r_sh;
  logic        w_half_end;
  logic        w_final;
  logic [2:0]  w_len;

  assign w_half_end = (r_cnt == LAST_CNT);
  assign w_final    = (r_bit == 3'd0) && ({1'b0, r_byte} == (r_len - 3'd1));
  assign w_len      = (length > 3'd4) ? 3'd4 : length;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)
        r_cnt <= 8'd0;
      else if (r_state != S_IDLE)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  // FINISH runs one extra count so the done cycle is still owned by FINISH
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start && (length != 3'd0)) w_nxt = S_SETUP;
      S_SETUP:  if (w_half_end) w_nxt = S_HIGH;
      S_HIGH:   if (w_half_end) w_nxt = w_final ? S_FINISH : S_LOW;
      S_LOW:    if (w_half_end) w_nxt = S_HIGH;
      S_FINISH: if (r_cnt == FIN_CNT) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data  <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_sclk <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_tx   <= 1'b0;
    end else begin
      done     <= 1'b0;
      spi_sclk <= (w_nxt == S_HIGH);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (length != 3'd0) begin
              r_tx     <= tx_data;
              r_len    <= w_len;
              r_byte   <= 2'd0;
              r_bit    <= 3'd7;
              spi_tx   <= tx_data[7];
              spi_cs_n <= 1'b0;
              busy     <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_SETUP, S_LOW: begin
          if (w_nxt == S_HIGH)
            r_sh <= {r_sh[6:0], spi_rx};
        end
        S_HIGH: begin
          if (w_nxt != S_HIGH) begin
            if (r_bit == 3'd0)
              rx_data[{r_byte, 3'b000} +: 8] <= r_sh;
            if (w_nxt == S_LOW) begin
              if (r_bit == 3'd0) begin
                r_byte <= r_byte + 2'd1;
                r_bit  <= 3'd7;
                spi_tx <= r_tx[{r_byte + 2'd1, 3'd7}];
              end else begin
                r_bit  <= r_bit - 3'd1;
                spi_tx <= r_tx[{r_byte, r_bit - 3'd1}];
              end
            end
          end
        end
        S_FINISH: begin
          if (r_cnt == LAST_CNT) begin
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            spi_tx   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_master_buffer.md
# spi_master_buffer

SPI initiator that serializes a 1-4 byte transmit buffer onto `spi_tx` (MOSI) and captures the same number of bytes from `spi_rx` (MISO) into a receive buffer. It is the driving end for the `spi_buffer` / `spi_byte` receive path: it generates `spi_sclk` and `spi_cs_n` from the system clock. It runs in SPI mode 0, MSB first, with SCLK held low whenever CS_N changes. The block lets in-fabric logic and test harnesses issue multi-byte SPI transactions without a host MCU.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `length`  in  3  number of bytes to transfer; 0 means none; values above 4 are clamped to 4. Latched on accept.
- `tx_data`  in  32  byte i is `tx_data[8i+7:8i]`; byte 0 is sent first. Latched on accept.
- `rx_data`  out  32  byte i is `rx_data[8i+7:8i]`; reset value 0.
- `busy`  out  1  high from the cycle after accept until `done`; reset value 0.
- `done`  out  1  one-cycle pulse at transaction end; reset value 0.
- `spi_sclk`  out  1  idles low; reset value 0.
- `spi_cs_n`  out  1  active low; reset value 1.
- `spi_tx`  out  1  MOSI; reset value 0; driven 0 when idle.
- `spi_rx`  in  1  MISO; sampled on the rising edge of `spi_sclk`.

## Operation
- The FSM has five states: IDLE, SETUP, HIGH, LOW and FINISH. A half-period counter counts 0..CLK_DIV-1 and reloads on every state change.
- **IDLE**
  - If `start` is high and `length` ≠ 0: latch `tx_data` and the clamped `length`. Enter SETUP.
  - If `start` is high and `length` = 0: pulse `done` on the next cycle. Leave `busy`, `spi_cs_n` and `rx_data` unchanged.
- **SETUP** (CLK_DIV cycles):
  - `spi_cs_n`=0, `spi_sclk`=0, `spi_tx` = bit 7 of byte 0.
  - Then go to HIGH.
- **HIGH** (CLK_DIV cycles):
  - `spi_sclk`=1.
  - On the cycle that enters HIGH, shift `spi_rx` into the receive shift register (MSB first).
  - Then go to LOW.
- **LOW** (CLK_DIV cycles):
  - `spi_sclk`=0. On entry, `spi_tx` advances to the next bit. After bit 0 of byte i, it moves to bit 7 of byte i+1.
  - After the 8th HIGH of byte i, the assembled byte is written to `rx_data` byte i on the LOW-entry cycle.
  - When the last bit of the last byte has been clocked, go to FINISH instead of advancing.
- **FINISH** (CLK_DIV cycles):
  - `spi_sclk`=0 and `spi_cs_n` held low.
  - Then `spi_cs_n`=1, `busy`=0, `spi_tx`=0, and `done`=1 for one cycle. Return to IDLE.
- Bytes of `rx_data` at or beyond `length` keep their previous values.
- `start` outside IDLE is ignored. Inputs are not queued.
- `reset` in any state returns to IDLE on the next edge with every output at its reset value, including `rx_data`=0. A partial SPI frame is abandoned: CS_N rises with SCLK low.
- Back-to-back: `start` may be high in the same cycle `done` is high. In that cycle the FSM is still in FINISH, so that `start` is ignored. A new transaction needs `start` high in IDLE, and CS_N stays high for at least 1 cycle between frames.

## Timing
- Accept edge = T (`start` sampled high in IDLE).
- `spi_cs_n` falls and `busy` rises at T+1.
- Rising SCLK edge k (k = 0 .. 8·length−1) occurs at T+1+CLK_DIV·(2k+1).
- `spi_tx` transitions occur only with `spi_sclk` low, CLK_DIV cycles before the next rising edge (setup = CLK_DIV clk periods).
- CS_N falls CLK_DIV cycles before the first rising edge and rises CLK_DIV cycles after the final falling edge.
- `done` occurs at T+1+CLK_DIV·(16·length+1). `spi_cs_n`=1 and `busy`=0 in that same cycle.
- `rx_data` byte i is valid from T+1+CLK_DIV·16·(i+1) onward, and all requested bytes are valid when `done` is high.

## Test plan
- **Loopback, 4 bytes.** CLK_DIV=2, `spi_rx` tied to `spi_tx`, `length`=4, `tx_data`=32'h33cc55aa, start at T.
  - Required: `done` at T+131 and `rx_data`=32'h33cc55aa.
  - Required: exactly 32 SCLK rising edges, and SCLK low at both CS_N edges.
- **Interop with receiver.** CLK_DIV=4, drive a `spi_buffer` instance with `length`=4, `tx_data`=32'hff00f00f.
  - Required: receiver `rx` = {0f, f0, 00, ff}.
  - Required: MOSI bit pattern MSB first: 00001111, 11110000, 00000000, 11111111.
- **Short frame then extend.** Preload `rx_data` with 32'hdeadbeef via a loopback transfer, then `length`=1, `tx_data`=32'h00000001.
  - Required: `rx_data`=32'hdeadbe01, `done` at T+1+17·CLK_DIV.
  - Then `length`=5 with 32'h04030201: clamped to 4, `rx_data`=32'h04030201.
- **Zero length.** `length`=0 with `start` high.
  - Required: `done` pulse at T+1, and `spi_cs_n` stays 1 throughout.
- **Ignored start.** Pulse `start` while `busy`=1, with different `tx_data`.
  - Required: the original frame completes unchanged, followed by no second frame.
- **Reset mid-transfer.** Assert `reset` for 1 cycle during byte 2 of a 4-byte frame.
  - Required on the next cycle: `spi_cs_n`=1, `spi_sclk`=0, `busy`=0, `rx_data`=0, and no `done` pulse.
  - A subsequent start completes normally.
